mem_responder: RTL and testbench

- Memory-side responder for the pipelined CPU's instruction and data request interface.
- Pipeline latches (IF/ID … MEM/WB) request instructions via iREN and data via dREN/dWEN, then advance on the ihit/dhit this block returns.
- Arbitrates the two request streams onto one single-port RAM, enforces a minimum access latency, and returns registered hit pulses with load data.

---
 rtl/mem_responder_pkg.sv | 16 +
 rtl/mem_responder_if.sv | 37 +++
 rtl/mem_wait_cnt.sv | 28 ++
 rtl/mem_responder.sv | 119 +++++++++++
 tb/tb_mem_responder.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the CPU memory responder.
package mem_responder_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DACC = 2'd1,
        IACC = 2'd2,
        RESP = 2'd3
    } mem_state_t;

    localparam word_t WORD_ALIGN_MASK = 32'hFFFF_FFFC;
    localparam int    CNT_W           = 4;

endpackage

// File: rtl/mem_responder_if.sv
// CPU request/response and RAM-side signals of the memory responder.
interface mem_responder_if
    import mem_responder_pkg::*;
#(
    parameter int ADDR_W = 32
) ();

    logic              iREN;
    logic [ADDR_W-1:0] iaddr;
    logic              dREN;
    logic              dWEN;
    logic [ADDR_W-1:0] daddr;
    word_t             dstore;
    logic              ihit;
    logic              dhit;
    word_t             iload;
    word_t             dmemload;
    logic              ramREN;
    logic              ramWEN;
    logic [ADDR_W-1:0] ramaddr;
    word_t             ramstore;
    word_t             ramload;
    logic              ram_ready;

    // Responder side
    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
        output ihit, dhit, iload, dmemload, ramREN, ramWEN, ramaddr, ramstore
    );

    // CPU pipeline plus RAM model side
    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
        input  ihit, dhit, iload, dmemload, ramREN, ramWEN, ramaddr, ramstore
    );

endinterface

// File: rtl/mem_wait_cnt.sv
// Purpose: loadable saturating down-counter with zero flag for RAM access latency.
// Latency: zero updates one cycle after load or after the final decrement.
// Backpressure: none; counts every cycle unless loaded.
module mem_wait_cnt
    import mem_responder_pkg::*;
(
    input  logic             CLK,
    input  logic             nrst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge CLK or negedge nrst) begin
        if (!nrst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mem_responder.sv
// Purpose: arbitrates instruction/data requests onto one single-port RAM and returns hit pulses.
// Latency: request-to-hit is WAIT_CYCLES+2 cycles minimum, plus one bubble between accesses.
// Backpressure: requests are held by the CPU until the matching hit; ram_ready stalls the access.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 32
) (
    input  logic          CLK,
    input  logic          nrst,
    mem_responder_if.slave bus
);

    mem_state_t        state, next_state;
    logic              acc_write;
    logic [ADDR_W-1:0] addr_q;
    word_t             store_q;
    word_t             iload_q;
    word_t             dmem_q;
    logic              ihit_q;
    logic              dhit_q;

    logic              any_d;
    logic              start_d;
    logic              start_i;
    logic              cnt_load;
    logic              cnt_zero;
    logic              abort;
    logic              done;
    logic [ADDR_W-1:0] start_addr;

    assign any_d    = bus.dREN | bus.dWEN;
    assign start_d  = (state == IDLE) && any_d;
    assign start_i  = (state == IDLE) && !any_d && bus.iREN;
    assign cnt_load = start_d | start_i;

    // Only reads may be cancelled (pipeline flush); a started write always completes.
    assign abort = ((state == IACC) && !bus.iREN) ||
                   ((state == DACC) && !acc_write && !bus.dREN);
    assign done  = ((state == DACC) || (state == IACC)) && cnt_zero &&
                   bus.ram_ready && !abort;

    assign start_addr = (start_d ? bus.daddr : bus.iaddr) & ~ADDR_W'(~WORD_ALIGN_MASK);

    mem_wait_cnt u_wait_cnt (
        .CLK      (CLK),
        .nrst     (nrst),
        .load     (cnt_load),
        .load_val (CNT_W'(WAIT_CYCLES)),
        .zero     (cnt_zero)
    );

    always_ff @(posedge CLK or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (any_d) begin
                    next_state = DACC;
                end else if (bus.iREN) begin
                    next_state = IACC;
                end
            end
            DACC, IACC: begin
                if (abort) begin
                    next_state = IDLE;
                end else if (done) begin
                    next_state = RESP;
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nrst) begin
        if (!nrst) begin
            acc_write <= 1'b0;
            addr_q    <= '0;
            store_q   <= '0;
            iload_q   <= '0;
            dmem_q    <= '0;
            ihit_q    <= 1'b0;
            dhit_q    <= 1'b0;
        end else begin
            ihit_q <= done && (state == IACC);
            dhit_q <= done && (state == DACC);
            if (cnt_load) begin
                addr_q    <= start_addr;
                store_q   <= bus.dstore;
                acc_write <= start_d && bus.dWEN;
            end
            if (done && (state == IACC)) begin
                iload_q <= bus.ramload;
            end
            if (done && (state == DACC) && !acc_write) begin
                dmem_q <= bus.ramload;
            end
        end
    end

    assign bus.ramREN   = (state == IACC) || ((state == DACC) && !acc_write);
    assign bus.ramWEN   = (state == DACC) && acc_write;
    assign bus.ramaddr  = addr_q;
    assign bus.ramstore = store_q;
    assign bus.ihit     = ihit_q;
    assign bus.dhit     = dhit_q;
    assign bus.iload    = iload_q;
    assign bus.dmemload = dmem_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: vector table plus hand-written corner sequences.
module tb_mem_responder;
    import mem_responder_pkg::*;

    localparam int WAIT = 2;

    logic clk;
    logic nrst;

    mem_responder_if #(.ADDR_W(32)) bus ();

    mem_responder #(.WAIT_CYCLES(WAIT), .ADDR_W(32)) dut (
        .CLK  (clk),
        .nrst (nrst),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit    is_d;
        word_t data;
    } exp_t;

    exp_t  sbq[$];
    word_t exp_iload = '0;
    word_t exp_dmem  = '0;

    // Scoreboard: each hit pops the oldest expected response.
    always @(negedge clk) begin
        if (nrst && (bus.ihit || bus.dhit)) begin
            exp_t e;
            check("hit_exclusive", 64'(bus.ihit & bus.dhit), 64'd0);
            if (sbq.size() == 0) begin
                check("unexpected_hit", 64'd1, 64'd0);
            end else begin
                e = sbq.pop_front();
                check("hit_port", 64'(bus.dhit), 64'(e.is_d));
                if (e.is_d) check("dmemload", 64'(bus.dmemload), 64'(e.data));
                else        check("iload", 64'(bus.iload), 64'(e.data));
            end
        end
    end

    task automatic push_exp(input bit is_d, input word_t data);
        exp_t e;
        e.is_d = is_d;
        e.data = data;
        sbq.push_back(e);
    endtask

    // Returns posedges elapsed until the hit is seen, or -1 on timeout.
    task automatic wait_hit(input bit is_d, output int lat);
        lat = -1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (is_d ? bus.dhit : bus.ihit) begin
                lat = n;
                break;
            end
        end
    endtask

    typedef struct {
        bit          i_req;
        bit          d_ren;
        bit          d_wen;
        logic [31:0] addr;
        word_t       store;
        word_t       rl;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs[6];

    task automatic apply_vec(input int idx, input vec_t v);
        int  lat;
        int  strobes;
        bit  first;
        bit  done;
        bit  is_wr;
        @(posedge clk);
        #1;
        is_wr = !v.i_req && v.d_wen;
        bus.ramload = v.rl;
        if (v.i_req) begin
            bus.iaddr = v.addr;
            bus.iREN  = 1'b1;
            push_exp(1'b0, v.rl);
            exp_iload = v.rl;
        end else begin
            bus.daddr  = v.addr;
            bus.dstore = v.store;
            bus.dREN   = v.d_ren;
            bus.dWEN   = v.d_wen;
            if (!is_wr) exp_dmem = v.rl;
            push_exp(1'b1, exp_dmem);
        end
        lat = 0; strobes = 0; first = 1'b1; done = 1'b0;
        while (!done && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (bus.ramREN || bus.ramWEN) begin
                strobes++;
                if (first) begin
                    first = 1'b0;
                    check($sformatf("v%0d_ramaddr", idx), 64'(bus.ramaddr), 64'(v.exp_addr));
                    check($sformatf("v%0d_ramREN", idx), 64'(bus.ramREN), 64'(!is_wr));
                    check($sformatf("v%0d_ramWEN", idx), 64'(bus.ramWEN), 64'(is_wr));
                    if (is_wr) check($sformatf("v%0d_ramstore", idx), 64'(bus.ramstore), 64'(v.store));
                end
            end
            if (bus.ihit || bus.dhit) done = 1'b1;
        end
        if (!done) check($sformatf("v%0d_timeout", idx), 64'd0, 64'd1);
        check($sformatf("v%0d_latency", idx), 64'(lat), 64'(WAIT + 2));
        check($sformatf("v%0d_strobe_cycles", idx), 64'(strobes), 64'(WAIT + 1));
        check($sformatf("v%0d_resp_no_strobe", idx), 64'(bus.ramREN | bus.ramWEN), 64'd0);
        bus.iREN = 1'b0;
        bus.dREN = 1'b0;
        bus.dWEN = 1'b0;
        @(posedge clk);
    endtask

    initial begin
        int lat;
        int bad;
        int hits;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0004, 32'h0,         32'h2008_0001, 32'h0000_0004};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 32'h0000_0100};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 32'h0000_0203, 32'h1234_5678, 32'h0BAD_0BAD, 32'h0000_0200};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 32'h0000_007F, 32'h0,         32'hCAFE_F00D, 32'h0000_007C};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 32'hFFFF_FFFE, 32'h0,         32'h0000_0000, 32'hFFFF_FFFC};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 32'h0000_0011, 32'hA5A5_A5A5, 32'h7777_7777, 32'h0000_0010};

        nrst          = 1'b0;
        bus.iREN      = 1'b0;
        bus.iaddr     = '0;
        bus.dREN      = 1'b0;
        bus.dWEN      = 1'b0;
        bus.daddr     = '0;
        bus.dstore    = '0;
        bus.ramload   = '0;
        bus.ram_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_hits",    64'({bus.ihit, bus.dhit}), 64'd0);
        check("rst_strobes", 64'({bus.ramREN, bus.ramWEN}), 64'd0);
        check("rst_ramaddr", 64'(bus.ramaddr), 64'd0);
        check("rst_loads",   64'({bus.iload, bus.dmemload}), 64'd0);
        nrst = 1'b1;

        for (int i = 0; i < 6; i++) apply_vec(i, vecs[i]);

        // Simultaneous requests: data first, one bubble, then the instruction access.
        @(posedge clk);
        #1;
        bus.ramload = 32'hDEAD_BEEF;
        bus.iaddr   = 32'h0000_0008;
        bus.daddr   = 32'h0000_0100;
        bus.iREN    = 1'b1;
        bus.dREN    = 1'b1;
        exp_dmem    = 32'hDEAD_BEEF;
        exp_iload   = 32'hDEAD_BEEF;
        push_exp(1'b1, exp_dmem);
        push_exp(1'b0, exp_iload);
        wait_hit(1'b1, lat);
        check("both_dhit_latency", 64'(lat), 64'(WAIT + 2));
        bus.dREN = 1'b0;
        wait_hit(1'b0, lat);
        check("both_ihit_after_dhit", 64'(lat), 64'(WAIT + 3));
        bus.iREN = 1'b0;
        @(posedge clk);

        // RAM not ready for 10 cycles: strobe held, no hit; hit in the cycle after ready is sampled.
        @(posedge clk);
        #1;
        bus.ram_ready = 1'b0;
        bus.ramload   = 32'h1111_2222;
        bus.iaddr     = 32'h0000_0040;
        bus.iREN      = 1'b1;
        exp_iload     = 32'h1111_2222;
        push_exp(1'b0, exp_iload);
        bad = 0;
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.ihit || !bus.ramREN) bad++;
        end
        check("notready_held", 64'(bad), 64'd0);
        @(posedge clk);
        #1;
        bus.ram_ready = 1'b1;
        wait_hit(1'b0, lat);
        check("notready_hit_after_ready", 64'(lat), 64'd1);
        bus.iREN = 1'b0;
        @(posedge clk);

        // Instruction read aborted by dropping iREN.
        @(posedge clk);
        #1;
        bus.ramload = 32'h9999_9999;
        bus.iaddr   = 32'h0000_0080;
        bus.iREN    = 1'b1;
        @(posedge clk);
        #1;
        bus.iREN = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_strobe_off", 64'(bus.ramREN), 64'd0);
        hits = 0;
        repeat (6) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.ihit) hits++;
        end
        check("abort_no_ihit", 64'(hits), 64'd0);
        check("abort_iload_kept", 64'(bus.iload), 64'(exp_iload));

        // Write with dWEN dropped mid-access still completes.
        @(posedge clk);
        #1;
        bus.daddr  = 32'h0000_0300;
        bus.dstore = 32'h0000_55AA;
        bus.dWEN   = 1'b1;
        push_exp(1'b1, exp_dmem);
        @(posedge clk);
        #1;
        bus.dWEN = 1'b0;
        wait_hit(1'b1, lat);
        check("wdrop_dhit_latency", 64'(lat), 64'(WAIT + 1));
        @(posedge clk);

        // Reset in the middle of a data access.
        @(posedge clk);
        #1;
        bus.ramload = 32'h4444_4444;
        bus.daddr   = 32'h0000_0500;
        bus.dREN    = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        nrst = 1'b0;
        #1;
        check("midrst_strobes", 64'({bus.ramREN, bus.ramWEN, bus.ihit, bus.dhit}), 64'd0);
        check("midrst_ramaddr", 64'(bus.ramaddr), 64'd0);
        check("midrst_loads",   64'({bus.iload, bus.dmemload}), 64'd0);
        bus.dREN  = 1'b0;
        exp_iload = '0;
        exp_dmem  = '0;
        @(posedge clk);
        @(negedge clk);
        nrst = 1'b1;
        hits = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.ihit || bus.dhit) hits++;
        end
        check("midrst_no_hit", 64'(hits), 64'd0);
        check("scoreboard_empty", 64'(sbq.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
